// File: rtl/ita_weight_serializer_pkg.sv
// Shared types and sizing for the ITA weight-buffer chunked write path.
// The weight serializer and its testbench import everything from here.
package ita_weight_serializer_pkg;

  localparam int unsigned N          = 4;
  localparam int unsigned M          = 4;
  localparam int unsigned WI         = 8;
  localparam int unsigned N_WRITE_EN = 8;

  // Counter width for a given number of chunks.
  // This is never less than one bit, so a single-chunk build still gets a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned TileWidth   = N * M * WI;
  localparam int unsigned WChunkWidth = N * M * WI / N_WRITE_EN;

  typedef logic [N-1:0][M-1:0][WI-1:0]         weight_t;
  typedef logic [WChunkWidth-1:0]              inp_weight_t;
  typedef logic [N_WRITE_EN-1:0]               write_select_t;
  typedef logic [idx_width(N_WRITE_EN)-1:0]    wchunk_idx_t;

  typedef enum logic {
    WSER_IDLE = 1'b0,
    WSER_SEND = 1'b1
  } wser_state_e;

endpackage

// File: rtl/ita_weight_serializer.sv
// Splits one accepted weight tile into NumChunks one-hot-selected write beats for the weight buffer.
// A tile is accepted back-to-back on the last beat, so tiles stream without idle cycles in between.
module ita_weight_serializer
  import ita_weight_serializer_pkg::*;
#(
  parameter  int unsigned NumChunks  = N_WRITE_EN,
  localparam int unsigned ChunkWidth = TileWidth / NumChunks,
  localparam int unsigned IdxWidth   = idx_width(NumChunks)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  tile_valid_i,
  output logic                  tile_ready_o,
  input  logic [TileWidth-1:0]  tile_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [NumChunks-1:0]  wr_sel_o,
  output logic [ChunkWidth-1:0] wr_data_o,
  output logic                  wr_last_o,
  output logic                  tile_done_o
);

  if ((N * M) % NumChunks != 0) begin : g_div_check
    $error("NumChunks must divide N*M");
  end

  wser_state_e           state_q, state_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [TileWidth-1:0]  tile_q, tile_d;
  logic                  done_q, done_d;
  logic                  sending, beat, accept;

  assign sending = (state_q == WSER_SEND);
  assign beat    = wr_valid_o && wr_ready_i;

  assign wr_valid_o = sending;
  assign wr_last_o  = sending && (idx_q == IdxWidth'(NumChunks - 1));
  assign wr_sel_o   = sending ? (NumChunks'(1) << idx_q) : '0;
  assign wr_data_o  = sending ? tile_q[idx_q*ChunkWidth +: ChunkWidth] : '0;

  // The only combinational path from wr_ready_i: the last beat frees the tile register.
  assign tile_ready_o = !clear_i && (!sending || (wr_last_o && wr_ready_i));
  assign accept       = tile_valid_i && tile_ready_o;
  assign tile_done_o  = done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tile_d  = tile_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = WSER_IDLE;
      idx_d   = '0;
      tile_d  = '0;
    end else begin
      if (beat) begin
        if (wr_last_o) begin
          state_d = WSER_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IdxWidth'(1);
        end
      end
      if (accept) begin
        state_d = WSER_SEND;
        idx_d   = '0;
        tile_d  = tile_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WSER_IDLE;
      idx_q   <= '0;
      tile_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tile_q  <= tile_d;
      done_q  <= done_d;
    end
  end

  a_sel_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    wr_valid_o |-> $onehot(wr_sel_o));

  a_stable_stall : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wr_valid_o && !wr_ready_i && !clear_i) |=>
      (wr_valid_o && $stable(wr_sel_o) && $stable(wr_data_o) && $stable(wr_last_o)));

endmodule
